// File: rtl/num_display_pkg.sv
// ---------------------------------------------------------------------------
// num_display_pkg
//   Shared types and constants for the 8-digit multiplexed 7-segment
//   seconds counter.
//   - bcd_t / bcd8_t : one BCD digit / eight packed BCD digits
//   - SEG_*          : active-low {g,f,e,d,c,b,a} patterns, SEG_BLANK = all off
//   - DS_NONE        : all digit enables inactive (active-low)
//   - seg_of()       : BCD digit -> segment pattern, non-BCD codes blank
// ---------------------------------------------------------------------------
package num_display_pkg;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [7:0] bcd8_t;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] DS_NONE   = 8'hFF;

  function automatic logic [6:0] seg_of(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/num_display_clk_divide.sv
// ---------------------------------------------------------------------------
// clk_divide
//   Turns the system clock into a one-cycle-wide tick every DIV cycles while
//   en is high. The tick is a clock enable, never a clock.
//   Ports:
//     clk     in   system clock
//     rst     in   asynchronous active-high reset
//     en      in   1 = run; 0 = hold the count at 0 and suppress the tick
//     clk_out out  tick, high for exactly one clk cycle
//   The first tick appears DIV cycles after en rises; dropping en discards
//   any partial count so the next period starts from scratch.
// ---------------------------------------------------------------------------
module clk_divide #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk_out
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_tick;

  // Tick is registered from the terminal-count compare, so it lands on the
  // cycle after div_cnt reaches DIV-1, i.e. exactly DIV edges after enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      if (r_div_cnt == CNT_W'(DIV - 1)) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
      r_tick <= (r_div_cnt == CNT_W'(DIV - 1));
    end
  end

  assign clk_out = r_tick;

endmodule

// File: rtl/num_display.sv
// ---------------------------------------------------------------------------
// num_display
//   8-digit multiplexed 7-segment seconds counter for a common-anode display.
//   Ports:
//     clk     in   1  system clock, sole clock domain
//     rst     in   1  asynchronous active-high reset
//     en_all  in   1  1 = count and display, 0 = freeze count and blank
//     clk_out out  1  count tick (TICK_HZ), one clk cycle wide
//     num     out  7  segments {g,f,e,d,c,b,a}, active-low
//     DS      out  8  digit enables, active-low, DS[0] = least significant
//   Contains the scan timer, the 8-digit BCD counter and the registered
//   output mux; the tick comes from a clk_divide instance.
// ---------------------------------------------------------------------------
module num_display
  import num_display_pkg::*;
#(
  parameter int CLK_HZ  = 1_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_all,
  output logic       clk_out,
  output logic [6:0] num,
  output logic [7:0] DS
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic              w_tick;
  bcd8_t             w_bcd_inc;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;
  bcd8_t             r_bcd;
  logic [7:0]        r_ds;
  logic [6:0]        r_num;

  clk_divide #(
    .DIV (TICK_DIV)
  ) u_clk_divide (
    .clk     (clk),
    .rst     (rst),
    .en      (en_all),
    .clk_out (w_tick)
  );

  assign clk_out = w_tick;

  // Scan timer free-runs regardless of en_all so the digit rotation never
  // stalls; only the outputs are blanked while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Ripple-carry BCD increment: the carry propagates through every digit
  // sitting at 9, so 99999999 naturally rolls over to 00000000.
  always_comb begin
    logic v_carry;
    w_bcd_inc = r_bcd;
    v_carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_carry) begin
        if (r_bcd[i] >= 4'd9) begin
          w_bcd_inc[i] = 4'd0;
        end else begin
          w_bcd_inc[i] = r_bcd[i] + 4'd1;
          v_carry      = 1'b0;
        end
      end
    end
  end

  // Count holds (not cleared) while en_all is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= '0;
    end else if (w_tick && en_all) begin
      r_bcd <= w_bcd_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ds  <= DS_NONE;
      r_num <= SEG_BLANK;
    end else if (en_all) begin
      r_ds  <= ~(8'b1 << r_idx);
      r_num <= seg_of(r_bcd[r_idx]);
    end else begin
      r_ds  <= DS_NONE;
      r_num <= SEG_BLANK;
    end
  end

  assign DS  = r_ds;
  assign num = r_num;

endmodule

// File: tb/tb_num_display.sv
module tb_num_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_all = 1'b0;
  logic       clk_out;
  logic [6:0] num;
  logic [7:0] DS;

  int n_cmp = 0;
  int n_bad = 0;

  num_display #(
    .CLK_HZ  (1000),
    .TICK_HZ (1),
    .SCAN_HZ (100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_all  (en_all),
    .clk_out (clk_out),
    .num     (num),
    .DS      (DS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Count held as a plain decimal integer; ticks derived from how many
  // consecutive edges en_all has been sampled high; digit index from the
  // number of edges since reset.
  int seg_tab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
  int pow10   [8]  = '{1, 10, 100, 1000, 10000, 100000, 1000000, 10000000};

  int         m_count = 0;
  int         m_scan  = 0;
  int         m_run   = 0;
  logic       m_tick  = 1'b0;
  logic [7:0] exp_ds  = 8'hFF;
  logic [6:0] exp_num = 7'h7F;
  logic       exp_tick = 1'b0;
  int         pre_req = 0;
  int         pre_seen = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    int idx;
    if (rst) begin
      m_count  = 0;
      m_scan   = 0;
      m_run    = 0;
      m_tick   = 1'b0;
      exp_ds   = 8'hFF;
      exp_num  = 7'h7F;
      exp_tick = 1'b0;
      pre_seen = pre_req;
    end else begin
      if (pre_req != pre_seen) begin
        m_count  = 99999999;
        pre_seen = pre_req;
      end
      idx = (m_scan / 10) % 8;
      if (en_all) begin
        exp_ds  = ~(8'b1 << idx);
        exp_num = 7'(seg_tab[(m_count / pow10[idx]) % 10]);
      end else begin
        exp_ds  = 8'hFF;
        exp_num = 7'h7F;
      end
      if (m_tick && en_all) m_count = (m_count + 1) % 100000000;
      m_scan   = (m_scan + 1) % 80;
      m_run    = en_all ? m_run + 1 : 0;
      m_tick   = en_all && (m_run % 1000 == 0);
      exp_tick = m_tick;
    end
  end

  always @(negedge clk) begin
    chk("clk_out", int'(clk_out), int'(exp_tick));
    chk("DS", int'(DS), int'(exp_ds));
    chk("num", int'(num), int'(exp_num));
    chk("one_digit", int'($countones(~DS) <= 1), 1);
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(output int c);
    c = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (clk_out) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic wait_ds(input logic [7:0] want, output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (DS == want) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int c, ok, c0, bad, pulses;

    // 1. reset and idle with en_all low
    repeat (3) @(negedge clk);
    chk("rst_ds", int'(DS), 'hFF);
    chk("rst_num", int'(num), 'h7F);
    chk("rst_tick", int'(clk_out), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_ds", int'(DS), 'hFF);
    chk("idle_num", int'(num), 'h7F);

    // 2/3. enable aligned with a fresh reset: scan walk and first tick
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en_all = 1'b1;
    c = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      case (i)
        1:  begin chk("scan_e1_ds", int'(DS), 'hFE);  chk("scan_e1_num", int'(num), 'h40); end
        10: chk("scan_e10_ds", int'(DS), 'hFE);
        11: begin chk("scan_e11_ds", int'(DS), 'hFD); chk("scan_e11_num", int'(num), 'h40); end
        80: chk("scan_e80_ds", int'(DS), 'h7F);
        81: chk("scan_e81_ds", int'(DS), 'hFE);
        default: ;
      endcase
      if (clk_out) begin
        c = i;
        break;
      end
    end
    chk("first_tick_delay", c, 1000);
    @(negedge clk);
    chk("tick_width", int'(clk_out), 0);
    wait_tick(c);
    chk("tick_period", c + 1, 1000);

    // 5. freeze after the 5th tick
    repeat (3) wait_tick(c);
    @(negedge clk);
    en_all = 1'b0;
    bad = 0;
    pulses = 0;
    repeat (3000) begin
      @(negedge clk);
      if (DS != 8'hFF) bad++;
      if (clk_out) pulses++;
    end
    chk("freeze_ds", bad, 0);
    chk("freeze_ticks", pulses, 0);
    en_all = 1'b1;
    c0 = cyc;
    wait_ds(8'hFE, ok);
    chk("resume_d0_found", ok, 1);
    chk("resume_d0_is5", int'(num), 'h12);
    wait_ds(8'hFD, ok);
    chk("resume_d1_is0", int'(num), 'h40);
    wait_tick(c);
    chk("resume_tick_delay", cyc - c0, 1000);
    repeat (2) @(negedge clk);
    wait_ds(8'hFE, ok);
    chk("resume_d0_is6", int'(num), 'h02);

    // 4. carry into digit 1 at the 10th tick
    repeat (4) wait_tick(c);
    repeat (2) @(negedge clk);
    wait_ds(8'hFE, ok);
    chk("carry_d0_is0", int'(num), 'h40);
    wait_ds(8'hFD, ok);
    chk("carry_d1_is1", int'(num), 'h79);
    wait_ds(8'hFB, ok);
    chk("carry_d2_is0", int'(num), 'h40);

    // 1. asynchronous reset in the middle of the high clock phase
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ds", int'(DS), 'hFF);
    chk("async_rst_num", int'(num), 'h7F);
    chk("async_rst_tick", int'(clk_out), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);
    chk("post_rst_ds", int'(DS), 'hFD);
    chk("post_rst_d1_cleared", int'(num), 'h40);

    // 4. preload 99999999, one tick wraps every digit to 0
    @(negedge clk);
    dut.r_bcd = 32'h9999_9999;
    pre_req++;
    repeat (2) @(negedge clk);
    wait_ds(8'h7F, ok);
    chk("preload_d7_is9", int'(num), 'h10);
    wait_tick(c);
    chk("preload_tick_seen", int'(c > 0), 1);
    repeat (2) @(negedge clk);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (DS != 8'hFF && num != 7'h40) bad++;
    end
    chk("wrap_all_zero", bad, 0);
    chk("model_wrap", m_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
